decoder_hamming_secded: RTL and testbench
=========================================

// Module: decoder_hamming_secded
// PURPOSE
//  Receive-side partner of the Hamming(16,11) SECDED encoder: takes 16-bit codewords, corrects any
//  single-bit error, detects double-bit errors, returns the 11 data bits plus status.
//  Two-stage pipeline with valid/ready flow control on both sides; sits between the channel/storage
//  read path and the data consumer.
//  Optional saturating error counters for link-health monitoring.
// PARAMETERS
//  CNT_W  16  width of each error counter (used only with HAMMING_DEC_STATS_EN)
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous, active-low reset
//  in_valid       in   1      code_in is valid
//  in_ready       out  1      block can accept a codeword this cycle
//  code_in        in   [0:15] codeword in encoder bit order (details below)
//  out_valid      out  1      data_out and the status outputs are valid
//  out_ready      in   1      consumer accepts the output this cycle
//  data_out       out  [0:10] decoded data; data_out[i] is the encoder's data_in[i]
//  err_corr       out  1      single error found and corrected (includes an error in c[15] only)
//  err_uncorr     out  1      double error detected; data_out is the uncorrected raw data
//  syndrome       out  [3:0]  Hamming syndrome, i.e. 1-based error position in c[0:14]; 0 = none
//  cnt_clr        in   1      synchronous clear of both counters     (HAMMING_DEC_STATS_EN only)
//  corr_cnt       out  CNT_W  count of corrected words                (HAMMING_DEC_STATS_EN only)
//  uncorr_cnt     out  CNT_W  count of uncorrectable words            (HAMMING_DEC_STATS_EN only)
// BEHAVIOUR
//  Codeword layout (c = code_in):
//   - c[i], i=0..14, is Hamming position i+1.
//   - Parity bits: c[0]=p0, c[1]=p1, c[3]=p2, c[7]=p3.
//   - Data bits: c[2]=d0, c[4..6]=d1..d3, c[8..14]=d4..d10.
//   - c[15] is overall parity: XOR of c[0..14].
//  Stage 1 (registered on input handshake in_valid&in_ready):
//   - Stores the codeword.
//   - Computes syndrome bit k as the XOR of c[i] over all i in 0..14 where bit k of (i+1) is set.
//   - Computes P = XOR of c[0..15].
//  Stage 2 (registered on advance into the output register):
//   - s==0, P==0 : clean; err_corr=0, err_uncorr=0.
//   - s!=0, P==1 : flip c[s-1]; err_corr=1.
//   - s==0, P==1 : error in c[15] only; data unchanged; err_corr=1.
//   - s!=0, P==0 : err_uncorr=1; data passed through uncorrected.
//   - In every case data_out is then extracted from the (possibly corrected) codeword.
//  Flow control:
//   - Latency is 2 cycles from input handshake to out_valid when there is no stall.
//   - Throughput is 1 word per cycle.
//   - A stage loads when it is empty or its contents move forward in the same cycle.
//   - in_ready = ~s1_valid | (~out_valid | out_ready). in_ready must not depend on in_valid.
//   - Output register holds data_out and all status stable while out_valid & ~out_ready.
//   - No word is dropped or duplicated under any out_ready pattern.
//  Reset (rst_n low, async, also mid-stream):
//   - All stage valids, out_valid, data_out, err_corr, err_uncorr, syndrome and counters go to 0.
//   - in_ready goes to 1.
//   - Words in flight are discarded.
// CONFIGURATION
//  HAMMING_DEC_STATS_EN defined:
//   - Ports cnt_clr, corr_cnt and uncorr_cnt exist.
//   - On each output handshake, corr_cnt increments if err_corr and uncorr_cnt increments if err_uncorr.
//   - Both counters saturate at all-ones.
//   - cnt_clr wins over a same-cycle increment (result is 0).
//  HAMMING_DEC_STATS_EN undefined:
//   - The three ports and all counter logic are absent.
//   - Datapath and timing are identical.
// TESTING
//  Example codeword: data d10=1, all other data 0 -> c[0:15] = 1101_0001_0000_0011.
//  1. Codeword above, out_ready=1 -> after 2 cycles data_out[0:10]=000_0000_0001, all status 0, syndrome=0.
//  2. Example codeword with c[6] flipped -> syndrome=7, err_corr=1, data_out=000_0000_0001, corr_cnt=1.
//  3. Example codeword with c[2] and c[5] flipped -> syndrome=5, err_uncorr=1, uncorr_cnt=1, err_corr=0.
//  4. Example codeword with c[15] flipped -> syndrome=0, err_corr=1, data_out unchanged.
//  5. Stream 8 words while out_ready toggles 1,0,0,1,...:
//     - all 8 appear in order with no loss or duplication;
//     - outputs are stable while stalled;
//     - in_ready drops once both stages are full.
//  6. Assert rst_n low with 2 words in flight -> out_valid=0 and counters 0 immediately (async);
//     the first word after release returns with 2-cycle latency.
//     Also: cnt_clr in the same cycle as an increment -> counter reads 0.

Source files
------------

// File: rtl/decoder_hamming_secded.sv
// Hamming(16,11) SECDED decoder, two-stage valid/ready pipeline.
// Stage 1 captures the raw data bits, the Hamming syndrome and the overall parity.
// Stage 2 applies the single-error correction and classifies the word into the output register.
// Optional feature macro: HAMMING_DEC_STATS_EN adds saturating corrected/uncorrectable word counters
// with a synchronous clear (ports cnt_clr, corr_cnt, uncorr_cnt).
module decoder_hamming_secded #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:15] code_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:10] data_out,
  output logic        err_corr,
  output logic        err_uncorr,
  output logic [3:0]  syndrome
`ifdef HAMMING_DEC_STATS_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
`endif
);

  // Syndrome: XOR of the 1-based positions of every set bit in c[0..14].
  function automatic logic [3:0] calc_syndrome(input logic [0:14] c);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (c[i]) begin
        s = s ^ 4'(i + 1);
      end
    end
    return s;
  endfunction

  // Hamming position (1-based) that carries data bit j.
  function automatic logic [3:0] data_pos(input logic [3:0] j);
    logic [3:0] p;
    case (j)
      4'd0:    p = 4'd3;
      4'd1:    p = 4'd5;
      4'd2:    p = 4'd6;
      4'd3:    p = 4'd7;
      4'd4:    p = 4'd9;
      4'd5:    p = 4'd10;
      4'd6:    p = 4'd11;
      4'd7:    p = 4'd12;
      4'd8:    p = 4'd13;
      4'd9:    p = 4'd14;
      4'd10:   p = 4'd15;
      default: p = 4'd0;
    endcase
    return p;
  endfunction

  // Flip the data bit sitting at Hamming position s; a parity-position syndrome leaves data intact.
  function automatic logic [0:10] fix_data(input logic [0:10] d, input logic [3:0] s);
    logic [0:10] r;
    r = d;
    for (int j = 0; j < 11; j++) begin
      if (data_pos(4'(j)) == s) begin
        r[j] = ~r[j];
      end
    end
    return r;
  endfunction

  logic        s1_valid_r;
  logic [0:10] s1_data_r;
  logic [3:0]  s1_syn_r;
  logic        s1_par_r;

  logic        out_adv_s;
  logic        in_fire_s;
  logic [0:10] nxt_data_s;
  logic        nxt_corr_s;
  logic        nxt_uncorr_s;

  // Stage 1 moves on when the output register is empty or being drained this cycle.
  assign out_adv_s = s1_valid_r & (~out_valid | out_ready);
  assign in_ready  = ~s1_valid_r | ~out_valid | out_ready;
  assign in_fire_s = in_valid & in_ready;

  // Stage 1 register: raw data bits, syndrome and overall parity of the accepted codeword.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= 11'd0;
      s1_syn_r   <= 4'd0;
      s1_par_r   <= 1'b0;
    end else if (in_fire_s) begin
      s1_valid_r <= 1'b1;
      s1_data_r  <= {code_in[2], code_in[4:6], code_in[8:14]};
      s1_syn_r   <= calc_syndrome(code_in[0:14]);
      s1_par_r   <= ^code_in;
    end else if (out_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Classify the stage-1 word and build the corrected data for the output register.
  always_comb begin
    nxt_data_s   = s1_data_r;
    nxt_corr_s   = 1'b0;
    nxt_uncorr_s = 1'b0;
    case ({s1_syn_r != 4'd0, s1_par_r})
      2'b00: begin
        nxt_corr_s = 1'b0;
      end
      2'b11: begin
        nxt_data_s = fix_data(s1_data_r, s1_syn_r);
        nxt_corr_s = 1'b1;
      end
      2'b01: begin
        nxt_corr_s = 1'b1;
      end
      2'b10: begin
        nxt_uncorr_s = 1'b1;
      end
      default: begin
        nxt_uncorr_s = 1'b0;
      end
    endcase
  end

  // Output register: loads on advance, holds while stalled, empties on a drain without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      data_out   <= 11'd0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      syndrome   <= 4'd0;
    end else if (out_adv_s) begin
      out_valid  <= 1'b1;
      data_out   <= nxt_data_s;
      err_corr   <= nxt_corr_s;
      err_uncorr <= nxt_uncorr_s;
      syndrome   <= s1_syn_r;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end else begin
      out_valid  <= out_valid;
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic out_fire_s;
  assign out_fire_s = out_valid & out_ready;

  // Saturating link-health counters, bumped on each output handshake; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= {CNT_W{1'b0}};
      uncorr_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      corr_cnt   <= {CNT_W{1'b0}};
      uncorr_cnt <= {CNT_W{1'b0}};
    end else begin
      if (out_fire_s && err_corr && (corr_cnt != CNT_MAX)) begin
        corr_cnt <= corr_cnt + CNT_ONE;
      end
      if (out_fire_s && err_uncorr && (uncorr_cnt != CNT_MAX)) begin
        uncorr_cnt <= uncorr_cnt + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_decoder_hamming_secded.sv
// Self-checking bench for decoder_hamming_secded: scoreboard queue filled by the driver,
// drained and compared by an independent monitor. Counter checks compile in only when
// HAMMING_DEC_STATS_EN is defined.
module tb_decoder_hamming_secded;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [0:15] code_in = 16'd0;
  logic        in_ready, out_valid, err_corr, err_uncorr;
  logic [0:10] data_out;
  logic [3:0]  syndrome;
`ifdef HAMMING_DEC_STATS_EN
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] corr_cnt, uncorr_cnt;
  int               exp_corr = 0, exp_uncorr = 0;
`endif

  typedef struct {
    logic [0:10] data;
    logic [3:0]  syn;
    logic        corr;
    logic        uncorr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   or_mode = 0;   // 0: ready=1, 1: random, 2: 1,0,0,1 pattern, 3: ready=0, other: untouched
  int   pidx = 0;

  decoder_hamming_secded #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .err_corr(err_corr),
    .err_uncorr(err_uncorr), .syndrome(syndrome)
`ifdef HAMMING_DEC_STATS_EN
    , .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference encoder: data bits fill the non-power-of-two positions in order, each parity
  // bit at position 2^k makes the XOR over positions with bit k set zero, c[15] is overall parity.
  function automatic logic [0:15] encode(input logic [0:10] d);
    logic [0:15] c;
    int j;
    c = 16'd0;
    j = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      logic x;
      x = 1'b0;
      for (int p = 1; p <= 15; p++) begin
        if (((p >> k) & 1) == 1) x = x ^ c[p-1];
      end
      c[(1 << k) - 1] = x;
    end
    c[15] = ^c[0:14];
    return c;
  endfunction

  // Build a codeword with nf distinct flipped bits and the response the decoder must give.
  function automatic void build(input logic [0:10] d, input int nf, input int f1, input int f2,
                                output logic [0:15] c, output exp_t e);
    int s;
    int j;
    c = encode(d);
    s = 0;
    if (nf >= 1) begin
      c[f1] = ~c[f1];
      if (f1 < 15) s = s ^ (f1 + 1);
    end
    if (nf >= 2) begin
      c[f2] = ~c[f2];
      if (f2 < 15) s = s ^ (f2 + 1);
    end
    e.syn    = 4'(s);
    e.corr   = (nf == 1);
    e.uncorr = (nf == 2);
    e.data   = d;
    if (nf == 2) begin
      j = 0;
      for (int p = 1; p <= 15; p++) begin
        if ((p & (p - 1)) != 0) begin
          e.data[j] = c[p-1];
          j++;
        end
      end
    end
  endfunction

  // Offer one codeword; the handshake happens at the posedge following the accepted negedge.
  task automatic send(input logic [0:15] c, input exp_t e);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    code_in  = c;
    #1;
    while (!in_ready && guard < 300) begin
      guard++;
      @(negedge clk);
      #1;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  // out_ready driver
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    forever begin
      @(negedge clk);
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin out_ready = pat[3 - (pidx % 4)]; pidx++; end
        3: out_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // Monitor: pops on output handshake, checks stall stability, tracks expected counters.
  initial begin
    exp_t        e;
    logic [17:0] prev;
    logic        prev_hold;
    prev_hold = 1'b0;
    prev = 18'd0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold)
          check("stall_hold", {out_valid, data_out, syndrome, err_corr, err_uncorr}, prev);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h required=none", data_out);
          end else begin
            e = sb.pop_front();
            check("data_out", data_out, e.data);
            check("syndrome", syndrome, e.syn);
            check("err_corr", err_corr, e.corr);
            check("err_uncorr", err_uncorr, e.uncorr);
          end
        end
`ifdef HAMMING_DEC_STATS_EN
        if (cnt_clr) begin
          exp_corr = 0;
          exp_uncorr = 0;
        end else if (out_valid && out_ready) begin
          if (err_corr && exp_corr < (1 << CNT_W) - 1) exp_corr++;
          if (err_uncorr && exp_uncorr < (1 << CNT_W) - 1) exp_uncorr++;
        end
`endif
        prev = {out_valid, data_out, syndrome, err_corr, err_uncorr};
        prev_hold = out_valid & ~out_ready;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:15] ex_code, c;
    logic [0:10] ex_data, d;
    exp_t        e;
    int          nf, f1, f2, guard;

    ex_code = 16'b1101_0001_0000_0011;
    ex_data = 11'b000_0000_0001;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data_out", data_out, 0);
    check("rst_status", {syndrome, err_corr, err_uncorr}, 0);
`ifdef HAMMING_DEC_STATS_EN
    check("rst_counters", {corr_cnt, uncorr_cnt}, 0);
`endif
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    or_mode = 0;

    // Example word, clean, plus 2-cycle latency
    e.data = ex_data; e.syn = 4'd0; e.corr = 1'b0; e.uncorr = 1'b0;
    send(ex_code, e);
    check("latency_edge1", out_valid, 0);
    @(posedge clk);
    #1;
    check("latency_edge2", out_valid, 1);
    drain();

    // Single error in c[6]
    e.data = ex_data; e.syn = 4'd7; e.corr = 1'b1; e.uncorr = 1'b0;
    send(ex_code ^ 16'b0000_0010_0000_0000, e);
    drain();
`ifdef HAMMING_DEC_STATS_EN
    check("corr_cnt_one", corr_cnt, 1);
`endif

    // Double error in c[2] and c[5]: raw data returned
    e.data = 11'b101_0000_0001; e.syn = 4'd5; e.corr = 1'b0; e.uncorr = 1'b1;
    send(ex_code ^ 16'b0010_0100_0000_0000, e);
    drain();
`ifdef HAMMING_DEC_STATS_EN
    check("uncorr_cnt_one", uncorr_cnt, 1);
`endif

    // Error in overall parity bit only
    e.data = ex_data; e.syn = 4'd0; e.corr = 1'b1; e.uncorr = 1'b0;
    send(ex_code ^ 16'b0000_0000_0000_0001, e);
    drain();

    // Randomized stream with random backpressure
    or_mode = 1;
    for (int n = 0; n < 150; n++) begin
      d  = 11'($urandom);
      nf = $urandom_range(0, 2);
      f1 = $urandom_range(0, 15);
      f2 = (f1 + $urandom_range(1, 15)) % 16;
      build(d, nf, f1, f2, c, e);
      send(c, e);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
    end
    drain();

    // Eight back-to-back words against the 1,0,0,1 ready pattern
    or_mode = 2;
    pidx = 0;
    for (int n = 0; n < 8; n++) begin
      d  = 11'($urandom);
      nf = $urandom_range(0, 2);
      f1 = $urandom_range(0, 15);
      f2 = (f1 + $urandom_range(1, 15)) % 16;
      build(d, nf, f1, f2, c, e);
      send(c, e);
    end
    drain();
    or_mode = 0;

`ifdef HAMMING_DEC_STATS_EN
    check("corr_cnt_model", corr_cnt, exp_corr);
    check("uncorr_cnt_model", uncorr_cnt, exp_uncorr);

    // Clear in the same cycle as a corrected-word handshake
    or_mode = 3;
    build(11'h2a5, 1, 9, 0, c, e);
    send(c, e);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("clr_setup_valid", out_valid, 1);
    or_mode = 4;
    @(negedge clk);
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    cnt_clr = 1'b0;
    #1;
    check("clr_wins_corr", corr_cnt, 0);
    check("clr_wins_uncorr", uncorr_cnt, 0);
    or_mode = 0;
    drain();
    // Leave some nonzero count behind for the async reset check
    e.data = ex_data; e.syn = 4'd7; e.corr = 1'b1; e.uncorr = 1'b0;
    send(ex_code ^ 16'b0000_0010_0000_0000, e);
    drain();
`endif

    // Mid-stream asynchronous reset with two words in flight
    or_mode = 3;
    repeat (2) @(posedge clk);
    build(11'h155, 0, 0, 0, c, e);
    send(c, e);
    build(11'h0f3, 1, 4, 0, c, e);
    send(c, e);
    @(negedge clk);
    #1;
    check("in_ready_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
`ifdef HAMMING_DEC_STATS_EN
    check("async_rst_counters", {corr_cnt, uncorr_cnt}, 0);
    exp_corr = 0;
    exp_uncorr = 0;
`endif
    or_mode = 0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    build(11'h3c9, 1, 12, 0, c, e);
    send(c, e);
    check("post_rst_edge1", out_valid, 0);
    @(posedge clk);
    #1;
    check("post_rst_edge2", out_valid, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
